udp_tx_arbiter: RTL
===================

// Module: udp_tx_arbiter
// PURPOSE
//  Shares the single UDP transmit channel of the ethernet_test core between two requesters:
//  the RTP audio packetizer (net_top, high priority) and a low-rate control/status requester.
//  Sequences each packet: latch payload, pulse send-valid, wait for send-done, enforce an
//  inter-packet gap, and recover from a hung MAC by timeout. Sits between net_top and ethernet_test.
// PARAMETERS
//  DATA_W          7680       payload bus width in bits (UDP_LENGTH*8, UDP_LENGTH=960)
//  LEN_W           16         length field width
//  TIMEOUT_CYCLES  1000000    max cycles in WAIT before abort (20 ms @ 50 MHz)
//  GAP_CYCLES      16         idle cycles forced between packets (>=1)
//  AUDIO_BURST     4          max consecutive audio grants while control is pending (>=1)
// PORTS
//  clk                   in   1       system clock (50 MHz)
//  rst                   in   1       asynchronous, active-high reset
//  a_req                 in   1       audio request; level, held until a_ack or a_err
//  a_data                in   DATA_W  audio payload; stable while a_req high
//  a_len                 in   LEN_W   audio payload length in bytes
//  a_ack                 out  1       1-cycle pulse: audio packet sent
//  a_err                 out  1       1-cycle pulse: audio packet aborted by timeout
//  c_req/c_data/c_len    in   1/DATA_W/LEN_W   control requester, same rules as audio
//  c_ack/c_err           out  1/1     control completion/abort pulses
//  udp_send_data_valid   out  1       1-cycle launch pulse to ethernet_test
//  udp_send_data         out  DATA_W  registered payload; stable from launch until done/abort
//  udp_send_data_length  out  LEN_W   registered length; same stability rule
//  udp_send_data_ready   in   1       1-cycle pulse from ethernet_test: packet transmitted
//  busy                  out  1       high in any state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; burst counter 0; timer 0. Reset mid-packet abandons it, no ack/err.
//  FSM IDLE -> LAUNCH -> WAIT -> GAP -> IDLE.
//  IDLE: if any req, choose winner, register data/len/owner, go LAUNCH (edge N).
//   Winner: audio if a_req, unless c_req and burst_cnt==AUDIO_BURST -> control.
//   burst_cnt: +1 on audio grant while c_req high (saturates); cleared on control grant or c_req low.
//  LAUNCH: udp_send_data_valid=1 for exactly this cycle (N+1); load timer; go WAIT.
//  WAIT: ready pulse -> owner ack pulse next cycle, go GAP. Timer hits 0 -> owner err pulse, go GAP.
//   Ready and expiry in same cycle: ready wins (ack, no err). Ready in IDLE/LAUNCH/GAP ignored.
//  GAP: count GAP_CYCLES, then IDLE; requests seen during GAP wait for IDLE.
//  Launch latency: req high at edge N -> valid high cycle N+1. Min packet period 3+GAP_CYCLES cycles.
//  Requester dropping req after grant: transfer completes, ack still issued.
//  Timer: down-counter width $clog2(TIMEOUT_CYCLES+1); no wrap, stops at 0.
// CONFIGURATION
//  UDP_TX_ARB_STATS_EN defined: adds outputs a_pkt_cnt, c_pkt_cnt, timeout_cnt (32 bit each,
//   saturating, reset 0), +1 on a_ack, c_ack, any err respectively.
//  Undefined: ports and counters absent; all other behaviour identical.
// STRUCTURE
//  Package udp_arb_pkg: FSM state encoding (IDLE/LAUNCH/WAIT/GAP), owner IDs OWN_AUDIO=0/OWN_CTRL=1.
//  Sub-module udp_arb_timer: loadable saturating down-counter shared by WAIT timeout and GAP.
//  Payload mux + registers, FSM, fairness counter stay in top.
// TESTING
//  a_req, len=960; ready 50 cycles after valid -> one valid pulse, a_ack 1 cycle after ready, busy low after GAP.
//  a_req,c_req both held, AUDIO_BURST=4 -> grant order A,A,A,A,C,A,A,A,A,C.
//  No ready, TIMEOUT_CYCLES=100 -> a_err exactly 101 cycles after valid, no a_ack; next req served.
//  Ready and timer expiry same cycle -> ack only, no err; stray ready in IDLE -> no ack.
//  rst asserted in WAIT -> all outputs 0 immediately; no ack/err; new req launches normally.
//  UDP_TX_ARB_STATS_EN: 3 audio ok, 1 ctrl ok, 1 timeout -> counts 3,1,1.

Source files
------------

// File: rtl/udp_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : udp_arb_pkg
//  Brief    : Shared types for the UDP transmit arbiter (FSM states, owners).
//  Revision : 1.0 - initial release
// ============================================================================
package udp_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        GAP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_AUDIO = 1'b0,
        OWN_CTRL  = 1'b1
    } owner_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/udp_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module   : udp_arb_timer
//  Brief    : Loadable down-counter that stops at zero; times both the WAIT
//             timeout and the inter-packet gap.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_arb_timer #(
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/udp_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : udp_tx_arbiter
//  Brief    : Shares the ethernet_test UDP transmit channel between the RTP
//             audio packetizer (priority) and a control/status requester.
//             Optional packet statistics: define UDP_TX_ARB_STATS_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module udp_tx_arbiter
    import udp_arb_pkg::*;
#(
    parameter int DATA_W         = 7680,
    parameter int LEN_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000000,
    parameter int GAP_CYCLES     = 16,
    parameter int AUDIO_BURST    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_req,
    input  logic [DATA_W-1:0] a_data,
    input  logic [LEN_W-1:0]  a_len,
    output logic              a_ack,
    output logic              a_err,
    input  logic              c_req,
    input  logic [DATA_W-1:0] c_data,
    input  logic [LEN_W-1:0]  c_len,
    output logic              c_ack,
    output logic              c_err,
    output logic              udp_send_data_valid,
    output logic [DATA_W-1:0] udp_send_data,
    output logic [LEN_W-1:0]  udp_send_data_length,
    input  logic              udp_send_data_ready,
    output logic              busy
`ifdef UDP_TX_ARB_STATS_EN
    ,
    output logic [31:0]       a_pkt_cnt,
    output logic [31:0]       c_pkt_cnt,
    output logic [31:0]       timeout_cnt
`endif
);

    localparam int c_tmr_w   = max_int($clog2(TIMEOUT_CYCLES + 1), $clog2(GAP_CYCLES + 1));
    localparam int c_burst_w = $clog2(AUDIO_BURST + 1);

    // Timer is reloaded with N-1 so the timed state lasts exactly N cycles.
    localparam logic [c_tmr_w-1:0]   c_tmo_load = c_tmr_w'(TIMEOUT_CYCLES - 1);
    localparam logic [c_tmr_w-1:0]   c_gap_load = c_tmr_w'(GAP_CYCLES - 1);
    localparam logic [c_burst_w-1:0] c_burst_max = c_burst_w'(AUDIO_BURST);

    arb_state_t          r_state;
    arb_state_t          w_next_state;
    owner_t              r_owner;
    logic [c_burst_w-1:0] r_burst_cnt;
    logic [DATA_W-1:0]   r_data;
    logic [LEN_W-1:0]    r_len;
    logic                r_a_ack;
    logic                r_a_err;
    logic                r_c_ack;
    logic                r_c_err;

    logic                w_grant;
    logic                w_grant_ctrl;
    logic                w_tmr_load;
    logic [c_tmr_w-1:0]  w_tmr_val;
    logic                w_tmr_zero;
    logic                w_done_ok;
    logic                w_done_err;

    udp_arb_timer #(
        .WIDTH (c_tmr_w)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Audio wins unless control has already waited out a full audio burst.
    assign w_grant      = (r_state == IDLE) && (a_req || c_req);
    assign w_grant_ctrl = c_req && (!a_req || (r_burst_cnt == c_burst_max));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        w_done_ok    = 1'b0;
        w_done_err   = 1'b0;
        case (r_state)
            IDLE: begin
                if (a_req || c_req) begin
                    w_next_state = LAUNCH;
                end
            end
            LAUNCH: begin
                w_next_state = WAIT;
                w_tmr_load   = 1'b1;
                w_tmr_val    = c_tmo_load;
            end
            WAIT: begin
                // A ready arriving on the expiry cycle still counts as success.
                if (udp_send_data_ready) begin
                    w_done_ok    = 1'b1;
                    w_next_state = GAP;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_gap_load;
                end else if (w_tmr_zero) begin
                    w_done_err   = 1'b1;
                    w_next_state = GAP;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = c_gap_load;
                end
            end
            GAP: begin
                if (w_tmr_zero) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owner     <= OWN_AUDIO;
            r_burst_cnt <= '0;
            r_data      <= '0;
            r_len       <= '0;
            r_a_ack     <= 1'b0;
            r_a_err     <= 1'b0;
            r_c_ack     <= 1'b0;
            r_c_err     <= 1'b0;
        end else begin
            r_a_ack <= w_done_ok  && (r_owner == OWN_AUDIO);
            r_a_err <= w_done_err && (r_owner == OWN_AUDIO);
            r_c_ack <= w_done_ok  && (r_owner == OWN_CTRL);
            r_c_err <= w_done_err && (r_owner == OWN_CTRL);

            if (w_grant) begin
                r_owner <= w_grant_ctrl ? OWN_CTRL : OWN_AUDIO;
                r_data  <= w_grant_ctrl ? c_data : a_data;
                r_len   <= w_grant_ctrl ? c_len : a_len;
            end

            if (!c_req) begin
                r_burst_cnt <= '0;
            end else if (w_grant) begin
                if (w_grant_ctrl) begin
                    r_burst_cnt <= '0;
                end else if (r_burst_cnt != c_burst_max) begin
                    r_burst_cnt <= r_burst_cnt + 1'b1;
                end
            end
        end
    end

    assign udp_send_data_valid  = (r_state == LAUNCH);
    assign udp_send_data        = r_data;
    assign udp_send_data_length = r_len;
    assign busy                 = (r_state != IDLE);
    assign a_ack                = r_a_ack;
    assign a_err                = r_a_err;
    assign c_ack                = r_c_ack;
    assign c_err                = r_c_err;

`ifdef UDP_TX_ARB_STATS_EN
    logic [31:0] r_a_pkt_cnt;
    logic [31:0] r_c_pkt_cnt;
    logic [31:0] r_timeout_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_pkt_cnt   <= '0;
            r_c_pkt_cnt   <= '0;
            r_timeout_cnt <= '0;
        end else begin
            if (r_a_ack && (r_a_pkt_cnt != '1)) begin
                r_a_pkt_cnt <= r_a_pkt_cnt + 1'b1;
            end
            if (r_c_ack && (r_c_pkt_cnt != '1)) begin
                r_c_pkt_cnt <= r_c_pkt_cnt + 1'b1;
            end
            if ((r_a_err || r_c_err) && (r_timeout_cnt != '1)) begin
                r_timeout_cnt <= r_timeout_cnt + 1'b1;
            end
        end
    end

    assign a_pkt_cnt   = r_a_pkt_cnt;
    assign c_pkt_cnt   = r_c_pkt_cnt;
    assign timeout_cnt = r_timeout_cnt;
`endif

endmodule
`default_nettype wire
